// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Main-memory port arbiter/sequencer (main_clk domain).        |
// |               Shares one memory port between prog-cache refills,          |
// |               data-cache refills and write-back FIFO drain. One           |
// |               transaction at a time; refill lines are returned to the     |
// |               cache refill FIFOs, write-backs are popped on completion.   |
// | Options     : MEM_ARB_TIMEOUT_EN - abort a WAIT after TIMEOUT cycles      |
// |               without mem_ack and set the sticky err flag.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int LINE_W  = 512,
    parameter int RADDR_W = 18,
    parameter int TIMEOUT = 255
) (
    input  logic               main_clk,
    input  logic               rst_n,
    input  logic               req_prog,
    input  logic [RADDR_W-1:0] req_prog_addr,
    input  logic               req_data,
    input  logic [RADDR_W-1:0] req_data_addr,
    input  logic               wb_empty,
    input  logic               wb_full,
    input  logic [31:0]        wb_addr,
    input  logic [31:0]        wb_data,
    output logic               wb_pop,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ack,
    input  logic [LINE_W-1:0]  mem_rdata,
    output logic               resp_prog_valid,
    output logic               resp_data_valid,
    output logic [LINE_W-1:0]  resp_line,
    output logic [7:0]         resp_addr,
    output logic               busy,
    output logic               err
);

    // FSM state encoding
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    // Transaction source encoding
    localparam logic [1:0] c_SRC_PROG = 2'd0;
    localparam logic [1:0] c_SRC_DATA = 2'd1;
    localparam logic [1:0] c_SRC_WB   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_src;
    logic               r_rr_last;       // 0: prog served last, 1: data served last
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_wb_pop;
    logic               r_resp_prog_valid;
    logic               r_resp_data_valid;
    logic [LINE_W-1:0]  r_resp_line;
    logic [7:0]         r_line_lo;
    logic [7:0]         r_resp_addr;

    logic               w_grant;
    logic [1:0]         w_src;
    logic               w_data_elig;
    logic [RADDR_W-1:0] w_line_addr;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LIMIT = 8'(TIMEOUT);

    logic [7:0] r_tmo_cnt;
    logic       r_err;
    logic [7:0] w_tmo_next;

    assign w_tmo_next = r_tmo_cnt + 8'd1;
`endif

    // Pick the next transaction source from the current request/FIFO levels
    always_comb begin
        w_grant     = 1'b0;
        w_src       = c_SRC_PROG;
        // A data refill may not overtake pending write-backs (read-after-write order)
        w_data_elig = req_data & wb_empty;
        if (wb_full) begin
            w_grant = 1'b1;
            w_src   = c_SRC_WB;
        end else if (req_prog && w_data_elig) begin
            w_grant = 1'b1;
            w_src   = r_rr_last ? c_SRC_PROG : c_SRC_DATA;
        end else if (req_prog) begin
            w_grant = 1'b1;
            w_src   = c_SRC_PROG;
        end else if (w_data_elig) begin
            w_grant = 1'b1;
            w_src   = c_SRC_DATA;
        end else if (!wb_empty) begin
            w_grant = 1'b1;
            w_src   = c_SRC_WB;
        end
    end

    assign w_line_addr = (w_src == c_SRC_DATA) ? req_data_addr : req_prog_addr;

    // Transaction sequencer: IDLE -> ISSUE -> WAIT -> (RESP | IDLE) -> IDLE
    always_ff @(posedge main_clk) begin
        if (!rst_n) begin
            r_state           <= c_S_IDLE;
            r_src             <= c_SRC_PROG;
            r_rr_last         <= 1'b0;
            r_mem_req         <= 1'b0;
            r_mem_we          <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_wdata       <= '0;
            r_wb_pop          <= 1'b0;
            r_resp_prog_valid <= 1'b0;
            r_resp_data_valid <= 1'b0;
            r_resp_line       <= '0;
            r_line_lo         <= '0;
            r_resp_addr       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo_cnt         <= '0;
            r_err             <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes default low
            r_wb_pop          <= 1'b0;
            r_resp_prog_valid <= 1'b0;
            r_resp_data_valid <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    // While a pop is in flight the FIFO head/flags still show the
                    // entry being popped, so no decision is taken in that cycle.
                    if (w_grant && !r_wb_pop) begin
                        r_src       <= w_src;
                        r_mem_we    <= (w_src == c_SRC_WB);
                        r_mem_addr  <= (w_src == c_SRC_WB) ? wb_addr
                                       : {{(32-RADDR_W){1'b0}}, w_line_addr};
                        r_mem_wdata <= wb_data;
                        r_line_lo   <= w_line_addr[7:0];
                        r_state     <= c_S_ISSUE;
                    end
                end

                c_S_ISSUE: begin
                    r_mem_req <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state   <= c_S_WAIT;
                end

                c_S_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_wb_pop <= 1'b1;
                            r_state  <= c_S_IDLE;
                        end else begin
                            r_resp_line       <= mem_rdata;
                            r_resp_addr       <= r_line_lo;
                            r_resp_prog_valid <= (r_src == c_SRC_PROG);
                            r_resp_data_valid <= (r_src == c_SRC_DATA);
                            r_state           <= c_S_RESP;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (w_tmo_next == c_TMO_LIMIT) begin
                        // Abandon the access; the source is re-arbitrated from IDLE
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= c_S_IDLE;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
`endif
                end

                c_S_RESP: begin
                    r_rr_last <= (r_src == c_SRC_DATA);
                    r_state   <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign wb_pop          = r_wb_pop;
    assign mem_req         = r_mem_req;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign resp_prog_valid = r_resp_prog_valid;
    assign resp_data_valid = r_resp_data_valid;
    assign resp_line       = r_resp_line;
    assign resp_addr       = r_resp_addr;
    assign busy            = (r_state != c_S_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign err = r_err;
`else
    // No timeout hardware: err is constant 0 and TIMEOUT has no effect
    assign err = 1'b0 & (TIMEOUT == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Directed self-checking bench for mem_arbiter.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int LINE_W  = 512;
    localparam int RADDR_W = 18;

    logic               main_clk = 1'b0;
    logic               rst_n    = 1'b0;
    logic               req_prog = 1'b0;
    logic [RADDR_W-1:0] req_prog_addr = '0;
    logic               req_data = 1'b0;
    logic [RADDR_W-1:0] req_data_addr = '0;
    logic               wb_empty = 1'b1;
    logic               wb_full  = 1'b0;
    logic [31:0]        wb_addr  = '0;
    logic [31:0]        wb_data  = '0;
    logic               wb_pop;
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_ack  = 1'b0;
    logic [LINE_W-1:0]  mem_rdata = '0;
    logic               resp_prog_valid;
    logic               resp_data_valid;
    logic [LINE_W-1:0]  resp_line;
    logic [7:0]         resp_addr;
    logic               busy;
    logic               err;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .LINE_W  (LINE_W),
        .RADDR_W (RADDR_W),
        .TIMEOUT (255)
    ) dut (
        .main_clk        (main_clk),
        .rst_n           (rst_n),
        .req_prog        (req_prog),
        .req_prog_addr   (req_prog_addr),
        .req_data        (req_data),
        .req_data_addr   (req_data_addr),
        .wb_empty        (wb_empty),
        .wb_full         (wb_full),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .wb_pop          (wb_pop),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .resp_prog_valid (resp_prog_valid),
        .resp_data_valid (resp_data_valid),
        .resp_line       (resp_line),
        .resp_addr       (resp_addr),
        .busy            (busy),
        .err             (err)
    );

    always #5 main_clk = ~main_clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_l(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for mem_req; an expired bound shows up as a failed check
    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check_b({tag, "_mem_req"}, mem_req, 1'b1);
    endtask

    // Serve one line read: check the issued access, ack after ack_delay cycles, check the response
    task automatic serve_read(input string tag, input logic is_data, input logic [31:0] exp_addr,
                              input logic [LINE_W-1:0] line, input int ack_delay);
        wait_req(tag);
        check_b({tag, "_mem_we"}, mem_we, 1'b0);
        check_w({tag, "_mem_addr"}, mem_addr, exp_addr);
        repeat (ack_delay) tick();
        check_b({tag, "_req_held"}, mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = line;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check_b({tag, "_req_drop"}, mem_req, 1'b0);
        check_b({tag, "_prog_vld"}, resp_prog_valid, !is_data);
        check_b({tag, "_data_vld"}, resp_data_valid, is_data);
        check_l({tag, "_line"}, resp_line, line);
        check_w({tag, "_resp_addr"}, {24'h0, resp_addr}, {24'h0, exp_addr[7:0]});
        if (is_data) req_data = 1'b0;
        else         req_prog = 1'b0;
        tick();
        check_b({tag, "_prog_vld_end"}, resp_prog_valid, 1'b0);
        check_b({tag, "_data_vld_end"}, resp_data_valid, 1'b0);
        check_b({tag, "_busy_end"}, busy, 1'b0);
        check_l({tag, "_line_hold"}, resp_line, line);
    endtask

    // Serve one write-back: check the issued access, ack at once, check the pop, then update FIFO flags
    task automatic serve_write(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                               input logic new_empty, input logic new_full);
        wait_req(tag);
        check_b({tag, "_mem_we"}, mem_we, 1'b1);
        check_w({tag, "_mem_addr"}, mem_addr, exp_addr);
        check_w({tag, "_mem_wdata"}, mem_wdata, exp_data);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_b({tag, "_req_drop"}, mem_req, 1'b0);
        check_b({tag, "_wb_pop"}, wb_pop, 1'b1);
        check_b({tag, "_busy"}, busy, 1'b0);
        check_b({tag, "_no_strobe"}, resp_prog_valid | resp_data_valid, 1'b0);
        tick();
        check_b({tag, "_wb_pop_end"}, wb_pop, 1'b0);
        wb_empty = new_empty;
        wb_full  = new_full;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_b("rst_mem_req", mem_req, 1'b0);
        check_b("rst_mem_we", mem_we, 1'b0);
        check_w("rst_mem_addr", mem_addr, 32'h0);
        check_w("rst_mem_wdata", mem_wdata, 32'h0);
        check_b("rst_wb_pop", wb_pop, 1'b0);
        check_b("rst_prog_vld", resp_prog_valid, 1'b0);
        check_b("rst_data_vld", resp_data_valid, 1'b0);
        check_l("rst_line", resp_line, '0);
        check_w("rst_resp_addr", {24'h0, resp_addr}, 32'h0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // Prog refill with per-cycle latency checks
        req_prog      = 1'b1;
        req_prog_addr = 18'h000A5;
        tick();
        check_b("t1_busy_issue", busy, 1'b1);
        check_b("t1_no_req_issue", mem_req, 1'b0);
        tick();
        check_b("t1_req_wait", mem_req, 1'b1);
        tick();
        serve_read("t1", 1'b0, 32'h000000A5, {16{32'hDEADBEEF}}, 2);

        // mem_ack while idle is ignored and the last line is held
        mem_ack   = 1'b1;
        mem_rdata = {16{32'h12345678}};
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check_b("idle_ack_busy", busy, 1'b0);
        check_b("idle_ack_strobe", resp_prog_valid | resp_data_valid, 1'b0);
        check_l("idle_ack_line", resp_line, {16{32'hDEADBEEF}});

        // Round-robin: data first (prog served last), then alternation D, P, D, P
        req_prog      = 1'b1;
        req_prog_addr = 18'h00011;
        req_data      = 1'b1;
        req_data_addr = 18'h30022;
        serve_read("rr1_data", 1'b1, 32'h00030022, {16{32'h11112222}}, 0);
        req_data      = 1'b1;
        req_data_addr = 18'h00033;
        serve_read("rr2_prog", 1'b0, 32'h00000011, {16{32'h33334444}}, 1);
        req_prog      = 1'b1;
        req_prog_addr = 18'h00044;
        serve_read("rr3_data", 1'b1, 32'h00000033, {16{32'h55556666}}, 0);
        serve_read("rr4_prog", 1'b0, 32'h00000044, {16{32'h77778888}}, 0);

        // Data refill waits behind a pending write-back
        req_data      = 1'b1;
        req_data_addr = 18'h00055;
        wb_empty      = 1'b0;
        wb_addr       = 32'h00000100;
        wb_data       = 32'h00000055;
        serve_write("raw_wb", 32'h00000100, 32'h00000055, 1'b1, 1'b0);
        serve_read("raw_data", 1'b1, 32'h00000055, {16{32'h9999AAAA}}, 2);

        // Full write-back FIFO beats a prog refill
        req_prog      = 1'b1;
        req_prog_addr = 18'h00077;
        wb_empty      = 1'b0;
        wb_full       = 1'b1;
        wb_addr       = 32'h00000200;
        wb_data       = 32'h0000ABCD;
        serve_write("full_wb", 32'h00000200, 32'h0000ABCD, 1'b1, 1'b0);
        serve_read("full_prog", 1'b0, 32'h00000077, {16{32'hBBBBCCCC}}, 0);

        // Reset in the middle of WAIT
        req_prog      = 1'b1;
        req_prog_addr = 18'h001FF;
        wait_req("mid_rst");
        tick();
        rst_n = 1'b0;
        tick();
        check_b("mid_rst_req", mem_req, 1'b0);
        check_b("mid_rst_busy", busy, 1'b0);
        check_b("mid_rst_pop", wb_pop, 1'b0);
        check_b("mid_rst_strobe", resp_prog_valid | resp_data_valid, 1'b0);
        req_prog = 1'b0;
        rst_n    = 1'b1;
        tick();
        check_b("post_rst_req", mem_req, 1'b0);
        check_b("post_rst_busy", busy, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No mem_ack: access abandoned after 255 WAIT cycles, err sticky
        req_prog      = 1'b1;
        req_prog_addr = 18'h00002;
        wait_req("tmo");
        repeat (254) tick();
        check_b("tmo_req_last", mem_req, 1'b1);
        check_b("tmo_err_before", err, 1'b0);
        tick();
        check_b("tmo_req_drop", mem_req, 1'b0);
        check_b("tmo_err", err, 1'b1);
        check_b("tmo_busy", busy, 1'b0);
        check_b("tmo_strobe", resp_prog_valid | resp_data_valid, 1'b0);
        req_prog = 1'b0;
        repeat (4) tick();
        check_b("tmo_err_sticky", err, 1'b1);
`else
        check_b("err_tied_low", err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
